wb_dmi_initiator: RTL
=====================

// Module: wb_dmi_initiator
// PURPOSE
//  Wishbone-slave to DMI bridge: the initiator end of the DM's DMI request/response handshake.
//  - A Wishbone master (SoC CPU or UART debug host) reads/writes DM registers through it.
//  - It replaces the JTAG DTM on the dmi_* ports of the debug module.
//  - Strictly one outstanding DMI transaction; bus is stalled while one is in flight.
// PARAMETERS
//  AdrWidth      32   Wishbone byte-address width; only adr[8:2] used (7-bit DMI word address)
//  TimeoutCycles 1024 max cycles waiting for dmi_resp_valid before err; 0 disables timeout
// PORTS
//  clk             in   1   clock
//  rst             in   1   asynchronous reset, active high
//  wb_cyc_i        in   1   Wishbone cycle
//  wb_stb_i        in   1   Wishbone strobe (pipelined mode)
//  wb_we_i         in   1   write enable
//  wb_adr_i        in   AdrWidth byte address
//  wb_sel_i        in   4   byte selects
//  wb_dat_i        in   32  write data
//  wb_dat_o        out  32  read data, valid with wb_ack_o
//  wb_ack_o        out  1   normal termination, 1-cycle pulse
//  wb_err_o        out  1   error termination, 1-cycle pulse
//  wb_stall_o      out  1   request not accepted this cycle
//  dmi_rst_n       out  1   DMI reset to DM, active low
//  dmi_req_valid   out  1   DMI request valid
//  dmi_req_ready   in   1   DMI request accepted
//  dmi_req         out  dm::dmi_req_t  {addr[6:0], op[1:0], data[31:0]}
//  dmi_resp_valid  in   1   DMI response valid
//  dmi_resp_ready  out  1   initiator accepts response
//  dmi_resp        in   dm::dmi_resp_t {data[31:0], resp[1:0]}
// BEHAVIOUR
//  Reset values: wb_ack_o=0, wb_err_o=0, wb_stall_o=1, wb_dat_o=0, dmi_req_valid=0, dmi_resp_ready=0, dmi_req='0, dmi_rst_n=0.
//  dmi_rst_n: flop, 0 in reset, 1 from first clk edge after rst deasserts.
//  FSM states IDLE, REQ, RESP, DONE, DRAIN; reset state is IDLE (wb_stall_o rises to 0 in IDLE after reset release).
//  IDLE: wb_stall_o=0. Accept on cyc&stb.
//    - Write with sel!=4'hF -> DONE with err; no DMI traffic.
//    - Otherwise latch addr=adr[8:2], op=we?WRITE(2):READ(1), data=dat_i -> REQ.
//  REQ: dmi_req_valid=1, dmi_req stable; leave when dmi_req_ready=1 -> RESP.
//  RESP: dmi_resp_ready=1; on dmi_resp_valid latch data -> DONE.
//    - err if resp!=DTM_SUCCESS(0).
//    - Timeout counter counts from REQ entry; at TimeoutCycles -> DONE with err, then DRAIN.
//  DONE: one cycle wb_ack_o xor wb_err_o; wb_dat_o=resp data on read ack, 0 otherwise.
//    - Next state IDLE, or DRAIN after timeout.
//  DRAIN: dmi_resp_ready=1, response discarded on dmi_resp_valid -> IDLE.
//    - If timed out in REQ, first complete the request handshake.
//  wb_stall_o=1 in every state except IDLE; ack/err never asserted outside DONE.
//  cyc dropped mid-transaction: DMI transaction still completes; no ack/err issued; returns to IDLE.
//  Response in same cycle as timeout expiry: response wins, no DRAIN.
//  adr[1:0] and adr above bit 8 ignored (aliasing allowed).
//  Reset mid-operation: immediate return to IDLE, all outputs to reset values; DM side restarted via dmi_rst_n.
// STRUCTURE
//  Shared package dm_pkg: dmi_req_t, dmi_resp_t, dtm_op_e (NOP/READ/WRITE), DTM_SUCCESS/DTM_BUSY/DTM_ERR; FSM enum local.
//  Single module, no sub-modules; timeout counter is $clog2(TimeoutCycles+1) bits.
// TESTING
//  Read adr 0x044 (dmstatus), DM returns data 0x00400C82 resp 0 -> dmi_req {0x11,READ}, wb_ack_o with dat 0x00400C82.
//  Write adr 0x040 dat 0x00000001 sel F -> dmi_req {0x10,WRITE,0x1}, ack 1 cycle after response, dat_o 0.
//  Write sel 4'h3 -> wb_err_o 1 cycle after accept, dmi_req_valid never rises.
//  dmi_req_ready held low 5 cycles, then resp 2 (DTM_ERR) -> req stable 5 cycles, wb_err_o.
//  TimeoutCycles=16, no response -> err at cycle 16; late response consumed in DRAIN; next read acks normally.
//  Back-to-back stb: stall=1 while busy, second request issued only after first ack; assert rst mid-RESP -> outputs reset.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared debug-module types: DMI request/response records, DTM opcodes and
// response codes used by every DMI initiator and the debug module itself.
package dm_pkg;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'd0,
    DTM_READ  = 2'd1,
    DTM_WRITE = 2'd2
  } dtm_op_e;

  typedef enum logic [1:0] {
    DTM_SUCCESS = 2'd0,
    DTM_RSVD    = 2'd1,
    DTM_ERR     = 2'd2,
    DTM_BUSY    = 2'd3
  } dtm_resp_e;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  // DM registers are 32-bit only; partial writes cannot be forwarded.
  function automatic logic full_word(input logic [3:0] sel);
    return (sel == 4'hF);
  endfunction

endpackage

// File: rtl/wb_dmi_initiator_if.sv
// Pipelined Wishbone slave port of the DMI initiator, grouped as one bundle.
interface wb_dmi_initiator_if #(
  parameter int AdrWidth = 32
);
  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_we_i;
  logic [AdrWidth-1:0] wb_adr_i;
  logic [3:0]          wb_sel_i;
  logic [31:0]         wb_dat_i;
  logic [31:0]         wb_dat_o;
  logic                wb_ack_o;
  logic                wb_err_o;
  logic                wb_stall_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o
  );
endinterface

// File: rtl/wb_dmi_initiator.sv
// Wishbone-slave to DMI bridge: turns single Wishbone accesses into one
// outstanding DMI request/response exchange with the debug module.
module wb_dmi_initiator
  import dm_pkg::*;
#(
  parameter int AdrWidth      = 32,
  parameter int TimeoutCycles = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  wb_dmi_initiator_if.slave      wb,
  output logic                   dmi_rst_n,
  output logic                   dmi_req_valid,
  input  logic                   dmi_req_ready,
  output dmi_req_t               dmi_req,
  input  logic                   dmi_resp_valid,
  output logic                   dmi_resp_ready,
  input  dmi_resp_t              dmi_resp
);

  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] TmoLast = (TimeoutCycles > 0) ? CntW'(TimeoutCycles - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RESP  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } fsm_e;

  fsm_e            state_r, state_n;
  dmi_req_t        req_r, req_n;
  logic [31:0]     rdata_r, rdata_n;
  logic            err_r, err_n;
  logic            timed_out_r, timed_out_n;
  logic            pending_r, pending_n;
  logic            abort_r, abort_n;
  logic [CntW-1:0] tmo_cnt_r, tmo_cnt_n;
  logic            tmo_hit_s;
  logic            accept_s;
  logic            term_s;

  logic            ack_r, werr_r, stall_r, req_valid_r, resp_ready_r, rst_n_r;
  logic [31:0]     dat_o_r;
  logic            unused_adr_s;

  assign unused_adr_s = ^{wb.wb_adr_i[AdrWidth-1:9], wb.wb_adr_i[1:0]};
  assign tmo_hit_s    = (TimeoutCycles > 0) && (tmo_cnt_r >= TmoLast);
  assign accept_s     = wb.wb_cyc_i && wb.wb_stb_i && !stall_r;

  // Next-state and datapath-capture logic of the bridge FSM.
  always_comb begin
    state_n     = state_r;
    req_n       = req_r;
    rdata_n     = rdata_r;
    err_n       = err_r;
    timed_out_n = timed_out_r;
    pending_n   = pending_r;
    abort_n     = abort_r;
    tmo_cnt_n   = tmo_cnt_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          abort_n     = 1'b0;
          timed_out_n = 1'b0;
          pending_n   = 1'b0;
          rdata_n     = '0;
          tmo_cnt_n   = '0;
          if (wb.wb_we_i && !full_word(wb.wb_sel_i)) begin
            err_n   = 1'b1;
            state_n = S_DONE;
          end else begin
            err_n      = 1'b0;
            req_n.addr = wb.wb_adr_i[8:2];
            req_n.op   = wb.wb_we_i ? DTM_WRITE : DTM_READ;
            req_n.data = wb.wb_dat_i;
            state_n    = S_REQ;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_REQ: begin
        tmo_cnt_n = tmo_cnt_r + CntW'(1);
        abort_n   = abort_r || !wb.wb_cyc_i;
        if (dmi_req_ready) begin
          state_n = S_RESP;
        end else if (tmo_hit_s) begin
          err_n       = 1'b1;
          timed_out_n = 1'b1;
          pending_n   = 1'b1;
          state_n     = S_DONE;
        end else begin
          state_n = S_REQ;
        end
      end
      S_RESP: begin
        tmo_cnt_n = tmo_cnt_r + CntW'(1);
        abort_n   = abort_r || !wb.wb_cyc_i;
        // A response arriving on the expiry cycle still completes normally.
        if (dmi_resp_valid) begin
          rdata_n = dmi_resp.data;
          err_n   = (dmi_resp.resp != DTM_SUCCESS);
          state_n = S_DONE;
        end else if (tmo_hit_s) begin
          err_n       = 1'b1;
          timed_out_n = 1'b1;
          pending_n   = 1'b0;
          state_n     = S_DONE;
        end else begin
          state_n = S_RESP;
        end
      end
      S_DONE: begin
        state_n = timed_out_r ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (pending_r) begin
          pending_n = !dmi_req_ready;
          state_n   = S_DRAIN;
        end else if (dmi_resp_valid) begin
          state_n = S_IDLE;
        end else begin
          state_n = S_DRAIN;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign term_s = (state_n == S_DONE) && !abort_n;

  // State, captured transaction context and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= S_IDLE;
      req_r        <= '0;
      rdata_r      <= '0;
      err_r        <= 1'b0;
      timed_out_r  <= 1'b0;
      pending_r    <= 1'b0;
      abort_r      <= 1'b0;
      tmo_cnt_r    <= '0;
      ack_r        <= 1'b0;
      werr_r       <= 1'b0;
      stall_r      <= 1'b1;
      dat_o_r      <= '0;
      req_valid_r  <= 1'b0;
      resp_ready_r <= 1'b0;
      rst_n_r      <= 1'b0;
    end else begin
      state_r      <= state_n;
      req_r        <= req_n;
      rdata_r      <= rdata_n;
      err_r        <= err_n;
      timed_out_r  <= timed_out_n;
      pending_r    <= pending_n;
      abort_r      <= abort_n;
      tmo_cnt_r    <= tmo_cnt_n;
      ack_r        <= term_s && !err_n;
      werr_r       <= term_s && err_n;
      stall_r      <= (state_n != S_IDLE);
      dat_o_r      <= (term_s && !err_n && (req_n.op == DTM_READ)) ? rdata_n : '0;
      req_valid_r  <= (state_n == S_REQ) || ((state_n == S_DRAIN) && pending_n);
      resp_ready_r <= (state_n == S_RESP) || ((state_n == S_DRAIN) && !pending_n);
      rst_n_r      <= 1'b1;
    end
  end

  assign wb.wb_ack_o   = ack_r;
  assign wb.wb_err_o   = werr_r;
  assign wb.wb_stall_o = stall_r;
  assign wb.wb_dat_o   = dat_o_r;
  assign dmi_req_valid  = req_valid_r;
  assign dmi_resp_ready = resp_ready_r;
  assign dmi_req        = req_r;
  assign dmi_rst_n      = rst_n_r;

endmodule
